// File: rtl/s1_rs_enc_lfsr.sv
// Systematic RS(255,239) encoder over GF(2^8): byte-serial LFSR remainder with a
// single registered output stage. Message bytes pass through, then 16 parity bytes.
module s1_rs_enc_lfsr #(
  parameter int K = 239
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_first,
  output logic       m_last,
  input  logic       m_ready
);

  // Handshake: a byte moves on a side when valid && ready at the rising edge;
  // the producer holds valid/data stable until that edge, and ready never waits on valid.

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  // g(x) = prod_{i=0..15} (x + alpha^i); returns g0..g15 (g16 = 1 is implicit).
  function automatic logic [15:0][7:0] gen_coeffs();
    logic [16:0][7:0] g;
    logic [7:0]       root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g[15:0];
  endfunction

  localparam logic [15:0][7:0] GEN    = gen_coeffs();
  localparam logic [7:0]       K_LAST = 8'(K - 1);

  typedef enum logic {
    ST_MSG = 1'b0,
    ST_PAR = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             run_q;
  logic [15:0][7:0] p_q, p_d;
  logic [7:0]       msg_cnt_q, msg_cnt_d;
  logic [3:0]       par_cnt_q, par_cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_first_q, m_first_d;
  logic             m_last_q, m_last_d;
  logic             load_en;
  logic             accept;
  logic [7:0]       fb;

  always_comb begin
    load_en   = !m_valid_q || m_ready;
    s_ready   = 1'b0;
    accept    = 1'b0;
    fb        = s_data ^ p_q[15];
    state_d   = state_q;
    p_d       = p_q;
    msg_cnt_d = msg_cnt_q;
    par_cnt_d = par_cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_first_d = m_first_q;
    m_last_d  = m_last_q;

    if (load_en) begin
      m_valid_d = 1'b0;
      m_first_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      ST_MSG: begin
        // run_q keeps s_ready low while reset is held and for the release cycle.
        s_ready = run_q && load_en;
        accept  = s_valid && s_ready;
        if (accept) begin
          p_d[0] = gf_mul(GEN[0], fb);
          for (int i = 1; i < 16; i++) p_d[i] = p_q[i-1] ^ gf_mul(GEN[i], fb);
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          m_first_d = (msg_cnt_q == 8'd0);
          if (msg_cnt_q == K_LAST) begin
            msg_cnt_d = 8'd0;
            state_d   = ST_PAR;
          end else begin
            msg_cnt_d = msg_cnt_q + 8'd1;
          end
        end
      end
      ST_PAR: begin
        if (load_en) begin
          // Plain shift-out; the register is all-zero after the 16th shift.
          m_valid_d = 1'b1;
          m_data_d  = p_q[15];
          p_d       = {p_q[14:0], 8'h00};
          m_last_d  = (par_cnt_q == 4'd15);
          if (par_cnt_q == 4'd15) begin
            par_cnt_d = 4'd0;
            state_d   = ST_MSG;
          end else begin
            par_cnt_d = par_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_MSG;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_MSG;
      run_q     <= 1'b0;
      p_q       <= '0;
      msg_cnt_q <= 8'd0;
      par_cnt_q <= 4'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      p_q       <= p_d;
      msg_cnt_q <= msg_cnt_d;
      par_cnt_q <= par_cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_first_q <= m_first_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_first = m_first_q;
  assign m_last  = m_last_q;

endmodule
